// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX/MEM register with two-entry skid buffer and flush; EX_MEM_BRANCH_RESOLVE_EN adds in-stage branch resolution
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_out,
  input  logic [2:0]        ctlm_out,
  input  logic [DATA_W-1:0] adder_out,
  input  logic              aluzero,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] readdat2,
  input  logic [REG_W-1:0]  muxout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic [DATA_W-1:0] add_result,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_W-1:0]  five_bit_muxout
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  ,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target
`endif
);
  localparam int EW = WB_W + 3 + 3 * DATA_W + 1 + REG_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [EW-1:0] main, skid, main_n, skid_n, in_entry;
  logic [WB_W-1:0] wb_q;
  logic [2:0] m_q;
  logic accept, pop, squash;
  assign in_entry = {ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdat2, muxout};
  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign {wb_q, m_q, add_result, zero, alu_result, rdata2out, five_bit_muxout} = main;
  assign wb_ctlout = out_valid ? wb_q : '0;
  assign {memwrite, memread, branch} = out_valid ? m_q : 3'b000;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  assign pc_src = out_valid & branch & zero;
  assign pc_target = add_result;
  // a taken branch leaving the stage makes everything behind it wrong-path
  assign squash = flush | (pc_src & pop);
`else
  assign squash = flush;
`endif
  always_comb begin
    state_n = state;
    main_n = main;
    skid_n = skid;
    if (squash) state_n = EMPTY;
    else
      case (state)
        EMPTY: if (accept) begin
          state_n = ONE;
          main_n = in_entry;
        end
        ONE: if (accept & pop) main_n = in_entry;
          else if (accept) begin
            state_n = FULL;
            skid_n = in_entry;
          end
          else if (pop) state_n = EMPTY;
        FULL: if (pop) begin
          state_n = ONE;
          main_n = skid;
        end
        default: state_n = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      main <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n != FULL;
      main <= main_n;
      skid <= skid_n;
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized scoreboard bench; the reference model is a bounded FIFO of capacity two.
module tb_ex_mem_stage;
  localparam int DW = 32, RW = 5, WW = 2;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, aluzero = 0, zero, branch, memread, memwrite;
  logic [WW-1:0] ctlwb_out = '0, wb_ctlout;
  logic [2:0] ctlm_out = '0;
  logic [DW-1:0] adder_out = '0, aluout = '0, readdat2 = '0, add_result, alu_result, rdata2out;
  logic [RW-1:0] muxout = '0, five_bit_muxout;
  int errors = 0, checks = 0, occ;
  bit acc = 0;
  typedef struct {
    logic [WW-1:0] wb;
    logic [2:0] m;
    logic [DW-1:0] add;
    logic z;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd2;
    logic [RW-1:0] mux;
  } ent_t;
  ent_t exp_q[$];
  ent_t e;

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW), .WB_W(WW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out), .aluzero(aluzero),
    .aluout(aluout), .readdat2(readdat2), .muxout(muxout), .out_valid(out_valid),
    .out_ready(out_ready), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
    .memwrite(memwrite), .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit r, input bit f, input logic [DW-1:0] alu);
    @(posedge clk);
    #1;
    in_valid = v;
    out_ready = r;
    flush = f;
    aluout = alu;
    ctlwb_out = WW'($urandom);
    ctlm_out = 3'($urandom);
    adder_out = $urandom;
    aluzero = 1'($urandom);
    readdat2 = $urandom;
    muxout = RW'($urandom);
    acc = v & in_ready & ~f;
    if (acc) exp_q.push_back('{ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdat2, muxout});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      occ = exp_q.size() - int'(acc);
      chk("out_valid", out_valid, occ > 0);
      chk("in_ready", in_ready, occ < 2);
      if (!out_valid) chk("ctl_gate", {wb_ctlout, branch, memread, memwrite}, 0);
      if (out_valid && out_ready && occ > 0) begin
        e = exp_q.pop_front();
        chk("entry", {wb_ctlout, memwrite, memread, branch, add_result, zero, alu_result, rdata2out, five_bit_muxout},
            {e.wb, e.m[2], e.m[1], e.m[0], e.add, e.z, e.alu, e.rd2, e.mux});
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    in_valid = 1;
    ctlwb_out = '1;
    ctlm_out = '1;
    aluout = 32'hdead_beef;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_outs", {wb_ctlout, branch, memread, memwrite, add_result, zero, alu_result, rdata2out, five_bit_muxout}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    step(1, 1, 0, 32'h1234);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 32'h11);
    step(1, 0, 0, 32'h22);
    step(1, 0, 0, 32'h33);
    step(1, 1, 0, 32'h33);
    step(1, 1, 0, 32'h33);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 32'haa);
    step(1, 0, 0, 32'hbb);
    step(1, 0, 1, 32'hcc);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0, i);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, $urandom);
    repeat (4) step(0, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
